// File: rtl/oddr_tx_pkg.sv
// oddr_tx_pkg: shared constants and helpers for the ODDR transmit serializer.
//   BIT_ORDER_LSB / BIT_ORDER_MSB : legal values of the BIT_ORDER parameter
//   DATA_WIDTH_MIN / _MAX         : legal bounds of DATA_WIDTH (which must also be even)
//   beat_cnt_width()              : width of the per-word beat counter
package oddr_tx_pkg;

    localparam string BIT_ORDER_LSB = "LSB_FIRST";
    localparam string BIT_ORDER_MSB = "MSB_FIRST";

    localparam int unsigned DATA_WIDTH_MIN = 4;
    localparam int unsigned DATA_WIDTH_MAX = 16;

    // clog2 of the beats per word; never narrower than one bit.
    function automatic int unsigned beat_cnt_width(input int unsigned data_width);
        int unsigned beats;
        beats = data_width / 2;
        return (beats > 2) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/oddr_out_cell.sv
// oddr_out_cell: DDR output stage. Registers a rise bit and a fall bit on posedge C and
// presents the rise bit on Q while C is high and the fall bit while C is low.
// Ports:
//   C  : clock
//   R  : synchronous active-high reset, loads RESET_VALUE into both halves
//   D1 : bit driven while C is high after the next posedge
//   D2 : bit driven while C is low after the next posedge
//   Q  : DDR output
module oddr_out_cell #(
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic C,
    input  logic R,
    input  logic D1,
    input  logic D2,
    output logic Q
);

    logic rise_q;
    logic fall_q;

    always_ff @(posedge C) begin
        if (R) begin
            rise_q <= RESET_VALUE;
            fall_q <= RESET_VALUE;
        end else begin
            rise_q <= D1;
            fall_q <= D2;
        end
    end

    // Clock-level select: the half-cycle mux that makes this a DDR output.
    assign Q = C ? rise_q : fall_q;

endmodule

// File: rtl/oddr_tx_serializer.sv
// oddr_tx_serializer: accepts parallel words into a one-entry holding register, shifts
// them out two bits per clock through a DDR output cell.
// Parameters:
//   DATA_WIDTH : word width, even, 4..16
//   IDLE_VALUE : level on Q (both halves) while no data is sent
//   BIT_ORDER  : "LSB_FIRST" or "MSB_FIRST"
// Ports:
//   C         : clock, all state changes on posedge
//   R         : synchronous active-high reset
//   D         : parallel word
//   D_VALID   : D holds a valid word
//   D_READY   : holding register empty and not in reset
//   Q         : DDR serial output (rise bit while C high, fall bit while C low)
//   TX_ACTIVE : output stage holds data bits
//   SENT      : one-cycle pulse after a word's last beat enters the output stage
// Build option:
//   ODDR_TX_TRAINING_EN : when defined, underrun emits rise=1/fall=0 (forwarded-clock
//                         pattern) instead of IDLE_VALUE.
module oddr_tx_serializer
    import oddr_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          IDLE_VALUE = 1'b0,
    parameter string       BIT_ORDER  = "LSB_FIRST"
) (
    input  logic                  C,
    input  logic                  R,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  D_VALID,
    output logic                  D_READY,
    output logic                  Q,
    output logic                  TX_ACTIVE,
    output logic                  SENT
);

    // Elaboration-time parameter checks.
    if ((DATA_WIDTH < DATA_WIDTH_MIN) || (DATA_WIDTH > DATA_WIDTH_MAX) ||
        ((DATA_WIDTH % 2) != 0)) begin : g_bad_width
        $error("oddr_tx_serializer: DATA_WIDTH must be even and within 4..16");
    end
    if (!((BIT_ORDER == BIT_ORDER_LSB) || (BIT_ORDER == BIT_ORDER_MSB))) begin : g_bad_order
        $error("oddr_tx_serializer: BIT_ORDER must be LSB_FIRST or MSB_FIRST");
    end

    localparam int unsigned         CntWidth = beat_cnt_width(DATA_WIDTH);
    localparam logic [CntWidth-1:0] LastBeat = CntWidth'(DATA_WIDTH / 2 - 1);
    localparam bit                  MsbFirst = (BIT_ORDER == BIT_ORDER_MSB);

`ifdef ODDR_TX_TRAINING_EN
    localparam bit UnderrunRise = 1'b1;
    localparam bit UnderrunFall = 1'b0;
`else
    localparam bit UnderrunRise = IDLE_VALUE;
    localparam bit UnderrunFall = IDLE_VALUE;
`endif

    logic                  hold_full_q;
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  shift_valid_q;
    logic [CntWidth-1:0]   beat_q;
    logic                  tx_active_q;
    logic                  sent_q;

    logic                  accept;
    logic                  last_beat;
    logic                  load;
    logic                  beat_rise;
    logic                  beat_fall;
    logic                  stage_rise;
    logic                  stage_fall;
    logic [DATA_WIDTH-1:0] shift_next;

    always_comb begin
        // Ready depends only on state and reset, never on D_VALID.
        D_READY   = ~hold_full_q & ~R;
        accept    = D_VALID & D_READY;
        last_beat = shift_valid_q & (beat_q == LastBeat);
        // Reload on the last beat too, so consecutive words stream without a gap.
        load      = hold_full_q & (~shift_valid_q | last_beat);

        if (MsbFirst) begin
            beat_rise  = shift_q[DATA_WIDTH-1];
            beat_fall  = shift_q[DATA_WIDTH-2];
            shift_next = shift_q << 2;
        end else begin
            beat_rise  = shift_q[0];
            beat_fall  = shift_q[1];
            shift_next = shift_q >> 2;
        end

        stage_rise = shift_valid_q ? beat_rise : UnderrunRise;
        stage_fall = shift_valid_q ? beat_fall : UnderrunFall;
    end

    always_ff @(posedge C) begin
        if (R) begin
            hold_full_q   <= 1'b0;
            hold_data_q   <= '0;
            shift_q       <= '0;
            shift_valid_q <= 1'b0;
            beat_q        <= '0;
            tx_active_q   <= 1'b0;
            sent_q        <= 1'b0;
        end else begin
            // Accept and load act on different registers; both may happen together.
            hold_full_q <= accept | (hold_full_q & ~load);
            if (accept) begin
                hold_data_q <= D;
            end

            if (load) begin
                shift_q       <= hold_data_q;
                shift_valid_q <= 1'b1;
                beat_q        <= '0;
            end else if (shift_valid_q) begin
                shift_q       <= shift_next;
                beat_q        <= last_beat ? '0 : beat_q + 1'b1;
                shift_valid_q <= ~last_beat;
            end

            // These track the beat entering the output cell on this same edge.
            tx_active_q <= shift_valid_q;
            sent_q      <= last_beat;
        end
    end

    assign TX_ACTIVE = tx_active_q;
    assign SENT      = sent_q;

    oddr_out_cell #(
        .RESET_VALUE(IDLE_VALUE)
    ) u_out_cell (
        .C (C),
        .R (R),
        .D1(stage_rise),
        .D2(stage_fall),
        .Q (Q)
    );

endmodule

// File: tb/tb_oddr_tx_serializer.sv
// tb_oddr_tx_serializer: self-checking bench for oddr_tx_serializer.
// Three instances: [0] width 8 LSB_FIRST idle 0, [1] width 4 MSB_FIRST idle 1,
// [2] width 16 LSB_FIRST idle 0. Expected values come from the word/bit-order rules
// and a bit-queue reference model.
module tb_oddr_tx_serializer;

    logic        c;
    logic [2:0]  rst;
    logic [2:0]  vld;
    logic [15:0] din [3];
    wire  [2:0]  rdy;
    wire  [2:0]  q;
    wire  [2:0]  act;
    wire  [2:0]  snt;

    // Per-cycle samples: rise half, fall half, flags after the posedge, accept before it.
    logic [2:0] s_rise, s_fall, s_act, s_sent, s_rdy, s_acc;

    int n_checks;
    int n_fail;

    bit idle_v [3];
    bit ur_r   [3];
    bit ur_f   [3];

    initial c = 1'b0;
    always #5 c = ~c;

    oddr_tx_serializer #(
        .DATA_WIDTH(8), .IDLE_VALUE(1'b0), .BIT_ORDER("LSB_FIRST")
    ) dut_lsb8 (
        .C(c), .R(rst[0]), .D(din[0][7:0]), .D_VALID(vld[0]), .D_READY(rdy[0]),
        .Q(q[0]), .TX_ACTIVE(act[0]), .SENT(snt[0])
    );

    oddr_tx_serializer #(
        .DATA_WIDTH(4), .IDLE_VALUE(1'b1), .BIT_ORDER("MSB_FIRST")
    ) dut_msb4 (
        .C(c), .R(rst[1]), .D(din[1][3:0]), .D_VALID(vld[1]), .D_READY(rdy[1]),
        .Q(q[1]), .TX_ACTIVE(act[1]), .SENT(snt[1])
    );

    oddr_tx_serializer #(
        .DATA_WIDTH(16), .IDLE_VALUE(1'b0), .BIT_ORDER("LSB_FIRST")
    ) dut_lsb16 (
        .C(c), .R(rst[2]), .D(din[2]), .D_VALID(vld[2]), .D_READY(rdy[2]),
        .Q(q[2]), .TX_ACTIVE(act[2]), .SENT(snt[2])
    );

    // One clock cycle: note accepts just before the posedge, sample both Q halves.
    task automatic tick();
        #1;
        s_acc = vld & rdy;
        @(posedge c);
        #1;
        s_rise = q;
        s_act  = act;
        s_sent = snt;
        s_rdy  = rdy;
        @(negedge c);
        #1;
        s_fall = q;
    endtask

    task automatic test_reset();
        rst = 3'b111;
        vld = 3'b111;
        for (int i = 0; i < 3; i++) din[i] = 16'($urandom);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({s_rdy[i], s_act[i], s_sent[i], s_rise[i], s_fall[i]} !==
                {3'b000, idle_v[i], idle_v[i]}) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: rdy/act/sent/rise/fall=%b%b%b%b%b expected 000%b%b",
                         i, s_rdy[i], s_act[i], s_sent[i], s_rise[i], s_fall[i],
                         idle_v[i], idle_v[i]);
            end
        end
        rst = 3'b000;
        vld = 3'b000;
        // Words presented during reset must have been dropped.
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({s_rdy[i], s_act[i], s_sent[i], s_rise[i], s_fall[i]} !==
                    {3'b100, ur_r[i], ur_f[i]}) begin
                    n_fail++;
                    $display("FAIL reset_release inst%0d cyc%0d: rdy/act/sent/rise/fall=%b%b%b%b%b expected 100%b%b",
                             i, k, s_rdy[i], s_act[i], s_sent[i], s_rise[i], s_fall[i],
                             ur_r[i], ur_f[i]);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] w;
        w = 8'hA5;
        din[0] = {8'h00, w};
        vld[0] = 1'b1;
        tick();
        n_checks++;
        if ({s_acc[0], s_rdy[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_accept: acc/rdy=%b%b expected 10", s_acc[0], s_rdy[0]);
        end
        vld[0] = 1'b0;
        tick();
        n_checks++;
        if ({s_act[0], s_rdy[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_latency: act/rdy=%b%b expected 01", s_act[0], s_rdy[0]);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({s_act[0], s_rise[0], s_fall[0], s_sent[0]} !==
                {1'b1, w[2*k], w[2*k+1], (k == 3)}) begin
                n_fail++;
                $display("FAIL single_beat%0d: act/rise/fall/sent=%b%b%b%b expected 1%b%b%b",
                         k, s_act[0], s_rise[0], s_fall[0], s_sent[0], w[2*k], w[2*k+1],
                         (k == 3));
            end
        end
        tick();
        n_checks++;
        if ({s_act[0], s_sent[0], s_rise[0], s_fall[0]} !== {2'b00, ur_r[0], ur_f[0]}) begin
            n_fail++;
            $display("FAIL single_tail: act/sent/rise/fall=%b%b%b%b expected 00%b%b",
                     s_act[0], s_sent[0], s_rise[0], s_fall[0], ur_r[0], ur_f[0]);
        end
    endtask

    task automatic test_back_to_back();
        int nacc, nact, first, last, acc_cyc0, acc_cyc1;
        logic [15:0] bits;
        nacc = 0; nact = 0; first = -1; last = -1; acc_cyc0 = -1; acc_cyc1 = -1;
        bits = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            din[0] = (nacc == 0) ? 16'h00FF : 16'h0000;
            vld[0] = (nacc < 2);
            tick();
            if (s_acc[0]) begin
                if (nacc == 0) acc_cyc0 = cyc;
                else acc_cyc1 = cyc;
                nacc++;
                n_checks++;
                if (s_rdy[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_rdy_after_accept cyc%0d: rdy=%b expected 0", cyc, s_rdy[0]);
                end
            end
            if (s_act[0]) begin
                if (first < 0) first = cyc;
                last = cyc;
                if (nact < 8) begin
                    bits[2*nact]   = s_rise[0];
                    bits[2*nact+1] = s_fall[0];
                end
                nact++;
            end
        end
        vld[0] = 1'b0;
        n_checks++;
        if (nacc != 2 || (acc_cyc1 - acc_cyc0) != 2) begin
            n_fail++;
            $display("FAIL b2b_accepts: count=%0d spacing=%0d expected 2 and 2",
                     nacc, acc_cyc1 - acc_cyc0);
        end
        n_checks++;
        if (nact != 8 || (last - first + 1) != 8) begin
            n_fail++;
            $display("FAIL b2b_gap: active beats=%0d span=%0d expected 8 and 8",
                     nact, last - first + 1);
        end
        n_checks++;
        if (bits !== 16'h00FF) begin
            n_fail++;
            $display("FAIL b2b_bits: stream=%h expected 00ff", bits);
        end
    endtask

    task automatic test_msb();
        din[1] = 16'h0008;
        vld[1] = 1'b1;
        tick();
        vld[1] = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({s_act[1], s_rise[1], s_fall[1], s_sent[1]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL msb_beat0: act/rise/fall/sent=%b%b%b%b expected 1100",
                     s_act[1], s_rise[1], s_fall[1], s_sent[1]);
        end
        tick();
        n_checks++;
        if ({s_act[1], s_rise[1], s_fall[1], s_sent[1]} !== 4'b1001) begin
            n_fail++;
            $display("FAIL msb_beat1: act/rise/fall/sent=%b%b%b%b expected 1001",
                     s_act[1], s_rise[1], s_fall[1], s_sent[1]);
        end
        tick();
        n_checks++;
        if ({s_act[1], s_rise[1], s_fall[1]} !== {1'b0, ur_r[1], ur_f[1]}) begin
            n_fail++;
            $display("FAIL msb_tail: act/rise/fall=%b%b%b expected 0%b%b",
                     s_act[1], s_rise[1], s_fall[1], ur_r[1], ur_f[1]);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] w;
        int bad;
        w = 16'($urandom);
        din[2] = w;
        vld[2] = 1'b1;
        tick();
        vld[2] = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({s_act[2], s_rise[2], s_fall[2]} !== {1'b1, w[2*k], w[2*k+1]}) begin
                n_fail++;
                $display("FAIL midrst_beat%0d: act/rise/fall=%b%b%b expected 1%b%b",
                         k, s_act[2], s_rise[2], s_fall[2], w[2*k], w[2*k+1]);
            end
        end
        // Reset lands on the edge after beat 3; a word offered with it is dropped.
        rst[2] = 1'b1;
        vld[2] = 1'b1;
        din[2] = ~w;
        tick();
        n_checks++;
        if ({s_act[2], s_sent[2], s_rdy[2], s_rise[2], s_fall[2]} !==
            {3'b000, idle_v[2], idle_v[2]}) begin
            n_fail++;
            $display("FAIL midrst_reset: act/sent/rdy/rise/fall=%b%b%b%b%b expected 000%b%b",
                     s_act[2], s_sent[2], s_rdy[2], s_rise[2], s_fall[2], idle_v[2], idle_v[2]);
        end
        rst[2] = 1'b0;
        vld[2] = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (s_act[2] || s_sent[2]) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midrst_flush: active/sent cycles=%0d expected 0", bad);
        end
        w = 16'($urandom);
        din[2] = w;
        vld[2] = 1'b1;
        tick();
        vld[2] = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if ({s_act[2], s_rise[2], s_fall[2], s_sent[2]} !==
                {1'b1, w[2*k], w[2*k+1], (k == 7)}) begin
                n_fail++;
                $display("FAIL midrst_next_beat%0d: act/rise/fall/sent=%b%b%b%b expected 1%b%b%b",
                         k, s_act[2], s_rise[2], s_fall[2], s_sent[2], w[2*k], w[2*k+1],
                         (k == 7));
            end
        end
    endtask

    task automatic test_underrun();
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({s_act[i], s_rise[i], s_fall[i]} !== {1'b0, ur_r[i], ur_f[i]}) begin
                    n_fail++;
                    $display("FAIL underrun inst%0d cyc%0d: act/rise/fall=%b%b%b expected 0%b%b",
                             i, k, s_act[i], s_rise[i], s_fall[i], ur_r[i], ur_f[i]);
                end
            end
        end
    endtask

    // Random valid/data against a bit-queue model of the serial stream.
    task automatic test_stress(input int i);
        bit          expq [$];
        int          w, popped, nwords, nsent;
        bit          msb, er, ef;
        logic [15:0] dw;
        w = (i == 1) ? 4 : ((i == 0) ? 8 : 16);
        msb = (i == 1);
        popped = 0; nwords = 0; nsent = 0;
        dw = '0;
        for (int cyc = 0; cyc < 430; cyc++) begin
            if (cyc < 400) begin
                vld[i] = ($urandom_range(0, 3) != 0);
                dw = 16'($urandom);
                din[i] = dw;
            end else begin
                vld[i] = 1'b0;
            end
            tick();
            if (s_acc[i]) begin
                nwords++;
                for (int k = 0; k < w; k++) expq.push_back(msb ? dw[w-1-k] : dw[k]);
            end
            n_checks++;
            if (s_act[i]) begin
                if (expq.size() < 2) begin
                    n_fail++;
                    $display("FAIL stress_extra_beat inst%0d cyc%0d: queued bits=%0d expected >=2",
                             i, cyc, expq.size());
                end else begin
                    er = expq.pop_front();
                    ef = expq.pop_front();
                    popped += 2;
                    if ({s_rise[i], s_fall[i]} !== {er, ef}) begin
                        n_fail++;
                        $display("FAIL stress_beat inst%0d cyc%0d: rise/fall=%b%b expected %b%b",
                                 i, cyc, s_rise[i], s_fall[i], er, ef);
                    end
                end
            end else if ({s_rise[i], s_fall[i]} !== {ur_r[i], ur_f[i]}) begin
                n_fail++;
                $display("FAIL stress_idle inst%0d cyc%0d: rise/fall=%b%b expected %b%b",
                         i, cyc, s_rise[i], s_fall[i], ur_r[i], ur_f[i]);
            end
            if (s_sent[i]) begin
                nsent++;
                n_checks++;
                if ((popped % w) != 0) begin
                    n_fail++;
                    $display("FAIL stress_sent_align inst%0d cyc%0d: bits out=%0d not a word multiple",
                             i, cyc, popped);
                end
            end
        end
        n_checks++;
        if (expq.size() != 0 || nsent != nwords) begin
            n_fail++;
            $display("FAIL stress_drain inst%0d: leftover bits=%0d sent=%0d words=%0d expected 0 and equal",
                     i, expq.size(), nsent, nwords);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_v   = '{1'b0, 1'b1, 1'b0};
`ifdef ODDR_TX_TRAINING_EN
        ur_r = '{1'b1, 1'b1, 1'b1};
        ur_f = '{1'b0, 1'b0, 1'b0};
`else
        ur_r = idle_v;
        ur_f = idle_v;
`endif
        rst = 3'b111;
        vld = 3'b000;
        for (int i = 0; i < 3; i++) din[i] = '0;

        test_reset();
        test_single();
        test_back_to_back();
        test_msb();
        test_mid_reset();
        test_underrun();
        for (int i = 0; i < 3; i++) test_stress(i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
